braille_cell_scheduler: RTL
===========================

Name: braille_cell_scheduler

Overview:
Sequences the six 6-bit braille cells produced by the braille time datapath (h_l, h_r, m_l, m_r, s_l, s_r) onto a single shared braille actuator, one cell at a time. Each frame request snapshots all six cells. The cells are then sent over a valid/ready handshake, with a programmable dwell gap after each cell so the pins can settle. Sits between braille_time and the actuator driver; the frame request is normally the 1 Hz seconds strobe.

Parameters:
DWELL_CYCLES, 4, idle cycles inserted after each accepted cell except the last; 0 = back-to-back.
DWELL_W, 16, width of the dwell counter; DWELL_CYCLES must fit in DWELL_W bits.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  frame request pulse
h_l, h_r, m_l, m_r, s_l, s_r  input  6 each  braille cell patterns from the time datapath
act_valid  output  1  cell offered to actuator
act_ready  input  1  actuator accepts cell
act_cell  output  6  cell pattern; 0 when act_valid=0
act_idx  output  3  cell index: 0=h_l, 1=h_r, 2=m_l, 3=m_r, 4=s_l, 5=s_r
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse after the last cell completes
overrun  output  1  sticky; a request was lost

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE. act_valid, act_cell, act_idx, busy, frame_done, overrun, pend and the snapshot registers all 0. Reset mid-frame abandons the frame without completing a handshake.
- States: IDLE, SEND, DWELL.
- IDLE:
  - Trigger = start | pend.
  - On a trigger edge: snapshot all six inputs, clear pend, set idx=0, go to SEND.
  - act_valid is high in the next cycle, so start-to-valid latency is 1 cycle.
- SEND:
  - act_valid=1; act_cell=snap[idx]; act_idx=idx.
  - Both are held stable until act_ready is sampled high.
  - On handshake with idx<5: idx+1, then DWELL, or SEND directly if DWELL_CYCLES=0.
  - On handshake with idx=5: go to IDLE, and pulse frame_done in the following cycle.
- DWELL:
  - act_valid=0; counter loads DWELL_CYCLES-1 on entry.
  - Returns to SEND when the counter reaches 0, giving exactly DWELL_CYCLES cycles with valid low.
- Snapshot isolation: input changes during a frame do not affect the cells being sent.
- start while busy:
  - If pend=0, set pend=1.
  - If pend=1 already, set overrun=1 (sticky until reset).
- start during the frame_done cycle: state is IDLE, so it is accepted directly.
- Back-to-back frames: if pend=1 at the frame_done cycle, the new snapshot is taken at that edge. act_valid returns one cycle later.
- act_ready while act_valid=0 is ignored.

Optional Feature:
BRAILLE_SKIP_UNCHANGED_EN
- Defined:
  - Keep last_sent[0..5] registers, reset to 0, plus a first_frame flag set by reset.
  - In SEND, if first_frame=0 and snap[idx]==last_sent[idx]: skip the cell with act_valid=0, spend 1 cycle, no dwell, advance idx.
  - last_sent[idx] is updated on each handshake; first_frame clears at the end of the first frame.
  - frame_done still pulses even if all six cells are skipped.
- Undefined: all six cells are always sent; no last_sent storage.

Decomposition:
- Package braille_pkg:
  - state enum (IDLE/SEND/DWELL)
  - NUM_CELLS=6, CELL_W=6, IDX_W=3
  - cell index constants CELL_H_L..CELL_S_R
- Sub-module braille_dwell_timer:
  - load/count-down/expired counter with a DWELL_W-bit parameter
  - instantiated once

Test Plan:
- Reset: hold rst 2 cycles mid-SEND -> every output 0 next cycle; no handshake completes.
- Basic frame, DWELL_CYCLES=4, act_ready=1, cells 12:34:56 patterns:
  - valid 1 cycle after start, six cells in idx order 0..5
  - 4 valid-low cycles between cells
  - frame_done 1 cycle after idx 5, total 6+5×4=26 cycles
- Backpressure: act_ready low 3 cycles on idx 2 -> act_cell/act_idx stable all 3 cycles; sequence continues correctly.
- Queued requests:
  - start twice during a frame -> pend set, overrun=0
  - second frame starts at the frame_done edge, snapshotting the new inputs
  - a third start mid-frame -> overrun=1 and stays set
- Snapshot isolation: change s_r mid-frame -> old s_r value sent; new value appears in the next frame.
- Skip feature, with BRAILLE_SKIP_UNCHANGED_EN defined: two frames with only s_r changed -> second frame has exactly one handshake (idx 5), and frame_done still pulses.

Source files
------------

// File: rtl/braille_pkg.sv
// Shared types and constants for the braille cell scheduler.
package braille_pkg;

    localparam int NUM_CELLS = 6;
    localparam int CELL_W    = 6;
    localparam int IDX_W     = 3;

    localparam logic [IDX_W-1:0] CELL_H_L = 3'd0;
    localparam logic [IDX_W-1:0] CELL_H_R = 3'd1;
    localparam logic [IDX_W-1:0] CELL_M_L = 3'd2;
    localparam logic [IDX_W-1:0] CELL_M_R = 3'd3;
    localparam logic [IDX_W-1:0] CELL_S_L = 3'd4;
    localparam logic [IDX_W-1:0] CELL_S_R = 3'd5;

    typedef enum logic [1:0] {IDLE, SEND, DWELL} state_t;
    typedef logic [CELL_W-1:0] cell_t;

endpackage

// File: rtl/braille_dwell_timer.sv
// Loadable down-counter; expired is high while the count is zero.
module braille_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               expired
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == '0);

endmodule

// File: rtl/braille_cell_scheduler.sv
// Snapshots six braille cells per frame request and sends them one by one over valid/ready with a dwell gap.
// Optional BRAILLE_SKIP_UNCHANGED_EN skips cells identical to the last ones sent.
module braille_cell_scheduler
    import braille_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int DWELL_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CELL_W-1:0] h_l,
    input  logic [CELL_W-1:0] h_r,
    input  logic [CELL_W-1:0] m_l,
    input  logic [CELL_W-1:0] m_r,
    input  logic [CELL_W-1:0] s_l,
    input  logic [CELL_W-1:0] s_r,
    output logic              act_valid,
    input  logic              act_ready,
    output logic [CELL_W-1:0] act_cell,
    output logic [IDX_W-1:0]  act_idx,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD =
        (DWELL_CYCLES > 0) ? DWELL_W'(DWELL_CYCLES - 1) : '0;

    state_t           state, state_nxt;
    cell_t            snap [NUM_CELLS];
    logic [IDX_W-1:0] idx;
    logic             pend;
    logic             trigger, hs, skip, advance, last, expired;

    assign trigger = start | pend;
    assign last    = (idx == CELL_S_R);
    assign hs      = (state == SEND) & ~skip & act_ready;
    assign advance = hs | skip;

`ifdef BRAILLE_SKIP_UNCHANGED_EN
    cell_t last_sent [NUM_CELLS];
    logic  first_frame;

    // The very first frame after reset always sends everything.
    assign skip = (state == SEND) & ~first_frame & (snap[idx] == last_sent[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++)
                last_sent[i] <= '0;
            first_frame <= 1'b1;
        end else begin
            if (hs)
                last_sent[idx] <= snap[idx];
            if (advance && last)
                first_frame <= 1'b0;
        end
    end
`else
    assign skip = 1'b0;
`endif

    braille_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (hs & ~last),
        .load_val (DWELL_LOAD),
        .en       (state == DWELL),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = SEND;
            SEND: begin
                if (advance) begin
                    if (last)
                        state_nxt = IDLE;
                    else if (hs && DWELL_CYCLES != 0)
                        state_nxt = DWELL;
                    else
                        state_nxt = SEND;
                end
            end
            DWELL:   if (expired) state_nxt = SEND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++)
                snap[i] <= '0;
            idx        <= CELL_H_L;
            pend       <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == SEND) & advance & last;
            if (state == IDLE) begin
                if (trigger) begin
                    snap[CELL_H_L] <= h_l;
                    snap[CELL_H_R] <= h_r;
                    snap[CELL_M_L] <= m_l;
                    snap[CELL_M_R] <= m_r;
                    snap[CELL_S_L] <= s_l;
                    snap[CELL_S_R] <= s_r;
                    idx            <= CELL_H_L;
                    pend           <= 1'b0;
                end
            end else begin
                // One request can wait behind the current frame; a second is lost.
                if (start) begin
                    if (pend)
                        overrun <= 1'b1;
                    else
                        pend <= 1'b1;
                end
                if (state == SEND && advance && !last)
                    idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        act_valid = (state == SEND) & ~skip;
        act_cell  = act_valid ? snap[idx] : '0;
        act_idx   = act_valid ? idx : '0;
        busy      = (state != IDLE);
    end

endmodule
